// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the user-area Wishbone slaves.
// Only address-window bytes and bus widths live here; there is no logic.
package wb_bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam logic [7:0] USER_BRAM_BASE_HI = 8'h38;
    localparam logic [7:0] USER_UART_BASE_HI = 8'h30;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

endpackage

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave to single-port BRAM: programmable wait states, one-shot BRAM access, byte-lane writes, oob ack.
// Ack DELAYS+1 cycles after the request is first seen; a strobe drop aborts, and a TURN cycle separates transactions.
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int         DELAYS  = 10,
    parameter int         ADDR_W  = 10,
    parameter logic [7:0] BASE_HI = USER_BRAM_BASE_HI
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [WB_SELW-1:0]  wbs_sel_i,
    input  logic [WB_DW-1:0]    wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [WB_DW-1:0]    wbs_dat_o,
    output logic                bram_en_o,
    output logic [WB_SELW-1:0]  bram_we_o,
    output logic [ADDR_W-1:0]   bram_addr_o,
    output logic [WB_DW-1:0]    bram_wdata_o,
    input  logic [WB_DW-1:0]    bram_rdata_i,
    output logic                oob_o,
    output logic                busy_o
);

    localparam logic [7:0] LAST_CNT = 8'(DELAYS - 1);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [WB_SELW-1:0]   sel_q, sel_d;
    logic [WB_DW-1:0]     wdat_q, wdat_d;
    logic                 oob_q, oob_d;

    logic valid;
    logic oob;
    logic unused_adr;

    assign valid      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
    assign oob        = |wbs_adr_i[23:ADDR_W+2];
    assign unused_adr = ^wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            oob_q   <= oob_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    addr_d  = wbs_adr_i[ADDR_W+1:2];
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    wdat_d  = wbs_dat_i;
                    oob_d   = oob;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A dropped strobe wins even on the access cycle.
                if (!valid) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o    = 1'b0;
        wbs_dat_o    = '0;
        oob_o        = 1'b0;
        bram_en_o    = 1'b0;
        bram_we_o    = '0;
        bram_addr_o  = '0;
        bram_wdata_o = '0;
        busy_o       = (state_q != IDLE);
        if (state_q != IDLE) begin
            bram_addr_o  = addr_q;
            bram_wdata_o = wdat_q;
        end
        if (state_q == WAIT && valid && cnt_q == LAST_CNT && !oob_q) begin
            bram_en_o = 1'b1;
            bram_we_o = we_q ? sel_q : '0;
        end
        if (state_q == ACK) begin
            wbs_ack_o = 1'b1;
            oob_o     = oob_q;
            if (!we_q && !oob_q) begin
                wbs_dat_o = bram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
module tb_wb_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic        ack;
    logic [31:0] rdat;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;
    logic        oob;
    logic        busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    wb_bram_ctrl #(.DELAYS(10), .ADDR_W(10), .BASE_HI(8'h38)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (wdat),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .bram_en_o    (bram_en),
        .bram_we_o    (bram_we),
        .bram_addr_o  (bram_addr),
        .bram_wdata_o (bram_wdata),
        .bram_rdata_i (bram_rdata),
        .oob_o        (oob),
        .busy_o       (busy)
    );

    // Single-port BRAM model with a one-cycle synchronous read.
    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= mem[bram_addr];
            for (int i = 0; i < 4; i++) begin
                if (bram_we[i]) mem[bram_addr][8*i +: 8] <= bram_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One request starting at cycle 0; records what the DUT did over 16 cycles.
    task automatic req(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input int drop_cyc, input int rst_cyc,
                       output int en_cnt, output int en_cyc, output logic [3:0] en_we,
                       output logic [9:0] en_addr, output int ack_cyc,
                       output logic [31:0] ack_dat, output logic ack_oob,
                       output logic busy_any, output logic we_any, output logic busy_post_rst);
        en_cnt = 0; en_cyc = -1; en_we = 4'h0; en_addr = 10'h0;
        ack_cyc = -1; ack_dat = 32'hX; ack_oob = 1'bX;
        busy_any = 1'b0; we_any = 1'b0; busy_post_rst = 1'bX;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; wdat = d;
        for (int c = 0; c < 16; c++) begin
            if (c == drop_cyc || (ack_cyc >= 0 && c == ack_cyc + 1)) begin
                cyc = 1'b0; stb = 1'b0;
            end
            if (c == rst_cyc) begin
                rst = 1'b1; cyc = 1'b0; stb = 1'b0;
            end else begin
                rst = 1'b0;
            end
            #1;
            if (rst_cyc >= 0 && c == rst_cyc + 1) busy_post_rst = busy;
            if (busy) busy_any = 1'b1;
            if (bram_we != 4'h0) we_any = 1'b1;
            if (bram_en) begin
                en_cnt++; en_cyc = c; en_we = bram_we; en_addr = bram_addr;
            end
            if (ack && ack_cyc < 0) begin
                ack_cyc = c; ack_dat = rdat; ack_oob = oob;
            end
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    int          en_cnt, en_cyc, ack_cyc;
    logic [3:0]  en_we;
    logic [9:0]  en_addr;
    logic [31:0] ack_dat;
    logic        ack_oob, busy_any, we_any, busy_post_rst;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bram_rdata = 32'h0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0; adr = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ack",   {31'h0, ack}, 32'h0);
        check("rst_en",    {31'h0, bram_en}, 32'h0);
        check("rst_we",    {28'h0, bram_we}, 32'h0);
        check("rst_oob",   {31'h0, oob}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_dat",   rdat, 32'h0);
        check("rst_addr",  {22'h0, bram_addr}, 32'h0);

        // Full-word write
        req(32'h3800_0010, 1'b1, 4'hF, 32'hA5A5_1234, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("wr_en_cnt",  en_cnt, 1);
        check("wr_en_cyc",  en_cyc, 10);
        check("wr_en_addr", {22'h0, en_addr}, 32'h4);
        check("wr_en_we",   {28'h0, en_we}, 32'hF);
        check("wr_ack_cyc", ack_cyc, 11);
        check("wr_ack_oob", {31'h0, ack_oob}, 32'h0);
        check("wr_ack_dat", ack_dat, 32'h0);

        // Read back
        req(32'h3800_0010, 1'b0, 4'hF, 32'h0, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("rd_en_cnt",  en_cnt, 1);
        check("rd_ack_cyc", ack_cyc, 11);
        check("rd_ack_dat", ack_dat, 32'hA5A5_1234);
        check("rd_we_any",  {31'h0, we_any}, 32'h0);

        // Byte-lane write then read
        req(32'h3800_0010, 1'b1, 4'b0010, 32'h0000_7700, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("bw_en_we",   {28'h0, en_we}, 32'h2);
        check("bw_en_cnt",  en_cnt, 1);
        check("bw_ack_cyc", ack_cyc, 11);
        req(32'h3800_0010, 1'b0, 4'hF, 32'h0, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("bw_rd_cyc",  ack_cyc, 11);
        check("bw_rd_dat",  ack_dat, 32'hA5A5_7734);

        // Strobe dropped in cycle 5 of a write
        req(32'h3800_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 5, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("ab_en_cnt",  en_cnt, 0);
        check("ab_ack_cyc", ack_cyc, -1);
        req(32'h3800_0010, 1'b0, 4'hF, 32'h0, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("ab_rd_cyc",  ack_cyc, 11);
        check("ab_rd_dat",  ack_dat, 32'hA5A5_7734);

        // Out-of-range read
        req(32'h3800_1000, 1'b0, 4'hF, 32'h0, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("oob_en_cnt",  en_cnt, 0);
        check("oob_ack_cyc", ack_cyc, 11);
        check("oob_ack_dat", ack_dat, 32'h0);
        check("oob_flag",    {31'h0, ack_oob}, 32'h1);

        // Non-decoded window
        req(32'h3000_0000, 1'b0, 4'hF, 32'h0, 12, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("nd_ack_cyc",  ack_cyc, -1);
        check("nd_busy",     {31'h0, busy_any}, 32'h0);
        check("nd_en_cnt",   en_cnt, 0);

        // Reset in cycle 6 of a write
        req(32'h3800_0010, 1'b1, 4'hF, 32'h1111_1111, -1, 6,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("rs_busy",    {31'h0, busy_post_rst}, 32'h0);
        check("rs_ack_cyc", ack_cyc, -1);
        check("rs_en_cnt",  en_cnt, 0);
        req(32'h3800_0010, 1'b0, 4'hF, 32'h0, -1, -1,
            en_cnt, en_cyc, en_we, en_addr, ack_cyc, ack_dat, ack_oob, busy_any, we_any, busy_post_rst);
        check("rs_rd_dat",  ack_dat, 32'hA5A5_7734);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
